// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// instruction classes, decode bundle, ALU function codes, datapath mux
// encodings and opcode/funct constants.
package mips_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RESET, S_FETCH, S_DECODE, S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB,
        S_MD_EXEC, S_MF_WB, S_LS_EXEC, S_LW_MEM, S_LW_WB, S_SW_MEM,
        S_BR_EXEC, S_J, S_JAL, S_JR, S_HALT, S_ILLEGAL
    } state_t;

    typedef enum logic [3:0] {
        CL_R, CL_I, CL_MD, CL_MF, CL_LW, CL_SW, CL_BR,
        CL_J, CL_JAL, CL_JR, CL_BRK, CL_ILL
    } cls_t;

    typedef struct packed {
        cls_t       cls;
        logic [4:0] fs;
        logic       tsel;
        logic [1:0] dest;
    } dec_t;

    // ALU function select codes
    localparam logic [4:0] FS_PASS_S = 5'd0,  FS_ADD  = 5'd1,  FS_ADDU = 5'd2,
                           FS_SUB    = 5'd3,  FS_SUBU = 5'd4,  FS_SLT  = 5'd5,
                           FS_SLTU   = 5'd6,  FS_AND  = 5'd7,  FS_OR   = 5'd8,
                           FS_XOR    = 5'd9,  FS_NOR  = 5'd10, FS_SLL  = 5'd11,
                           FS_SRL    = 5'd12, FS_SRA  = 5'd13, FS_LUI  = 5'd14,
                           FS_MUL    = 5'd15, FS_MULU = 5'd16, FS_DIV  = 5'd17,
                           FS_DIVU   = 5'd18;

    localparam logic [2:0] YS_HI = 3'd0, YS_LO = 3'd1, YS_ALU = 3'd2, YS_DIN = 3'd3, YS_PC = 3'd4;
    localparam logic [1:0] DS_RD = 2'd0, DS_RT = 2'd1, DS_R31 = 2'd2, DS_SP = 2'd3;
    localparam logic [1:0] PS_INC = 2'd0, PS_BR = 2'd1, PS_RS = 2'd2, PS_JMP = 2'd3;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                           OP_BEQ     = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                           OP_SLTI    = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                           OP_XORI    = 6'h0E, OP_LUI  = 6'h0F, OP_LW   = 6'h23,
                           OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03,
                           FN_JR   = 6'h08, FN_BREAK = 6'h0D, FN_MFHI = 6'h10,
                           FN_MFLO = 6'h12, FN_MULT  = 6'h18, FN_MULTU = 6'h19,
                           FN_DIV  = 6'h1A, FN_DIVU  = 6'h1B, FN_ADD  = 6'h20,
                           FN_ADDU = 6'h21, FN_SUB   = 6'h22, FN_SUBU = 6'h23,
                           FN_AND  = 6'h24, FN_OR    = 6'h25, FN_XOR  = 6'h26,
                           FN_NOR  = 6'h27, FN_SLT   = 6'h2A, FN_SLTU = 6'h2B;

    function automatic logic [4:0] fs_of_funct(input logic [5:0] fn);
        case (fn)
            FN_ADD:   return FS_ADD;   FN_ADDU:  return FS_ADDU;
            FN_SUB:   return FS_SUB;   FN_SUBU:  return FS_SUBU;
            FN_AND:   return FS_AND;   FN_OR:    return FS_OR;
            FN_XOR:   return FS_XOR;   FN_NOR:   return FS_NOR;
            FN_SLT:   return FS_SLT;   FN_SLTU:  return FS_SLTU;
            FN_SLL:   return FS_SLL;   FN_SRL:   return FS_SRL;
            FN_SRA:   return FS_SRA;   FN_MULT:  return FS_MUL;
            FN_MULTU: return FS_MULU;  FN_DIV:   return FS_DIV;
            FN_DIVU:  return FS_DIVU;
            default:  return FS_PASS_S;
        endcase
    endfunction

endpackage

// File: rtl/mcu_decode.sv
// Combinational instruction decoder.
// i_ir  : instruction register
// o_dec : instruction class, ALU function, RT-source select, destination select
module mcu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] i_ir,
    output dec_t        o_dec
);

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic       w_unused_ir;

    assign w_op        = i_ir[31:26];
    assign w_fn        = i_ir[5:0];
    // register/immediate fields are consumed by the datapath, not here
    assign w_unused_ir = ^i_ir[25:6];

    always_comb begin
        o_dec = '{cls: CL_ILL, fs: FS_PASS_S, tsel: 1'b0, dest: DS_RD};
        case (w_op)
            OP_SPECIAL: begin
                o_dec.fs = fs_of_funct(w_fn);
                case (w_fn)
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR,
                    FN_NOR, FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA:
                                                          o_dec.cls = CL_R;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:   o_dec.cls = CL_MD;
                    FN_MFHI, FN_MFLO:                     o_dec.cls = CL_MF;
                    FN_JR:                                o_dec.cls = CL_JR;
                    FN_BREAK:                             o_dec.cls = CL_BRK;
                    default:                              o_dec.cls = CL_ILL;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                o_dec.cls  = CL_I;
                o_dec.tsel = 1'b1;
                o_dec.dest = DS_RT;
                case (w_op)
                    OP_ADDI: o_dec.fs = FS_ADD;
                    OP_SLTI: o_dec.fs = FS_SLT;
                    OP_ANDI: o_dec.fs = FS_AND;
                    OP_ORI:  o_dec.fs = FS_OR;
                    OP_XORI: o_dec.fs = FS_XOR;
                    default: o_dec.fs = FS_LUI;
                endcase
            end
            OP_LW:  o_dec = '{cls: CL_LW, fs: FS_ADD, tsel: 1'b1, dest: DS_RT};
            OP_SW:  o_dec = '{cls: CL_SW, fs: FS_ADD, tsel: 1'b1, dest: DS_RT};
            OP_BEQ, OP_BNE: o_dec = '{cls: CL_BR, fs: FS_SUB, tsel: 1'b0, dest: DS_RD};
            OP_J:   o_dec.cls = CL_J;
            OP_JAL: o_dec = '{cls: CL_JAL, fs: FS_PASS_S, tsel: 1'b0, dest: DS_R31};
            default: o_dec.cls = CL_ILL;
        endcase
    end

endmodule

// File: rtl/mips_control_unit.sv
// Multi-cycle MIPS control unit: state register plus Moore output decode.
// Inputs : clk, reset (async, active low), IR, ALU flags N/Z/C/V.
// Outputs: PC/IR/memory strobes, regfile/HILO/mux controls, FS, halt/illegal.
// All outputs are forced to 0 while reset is low.
module mips_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter bit STRICT_ILLEGAL = 1'b1,
    parameter int FS_W           = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     IR,
    input  logic            N,
    input  logic            Z,
    input  logic            C,
    input  logic            V,
    output logic            pc_ld,
    output logic            pc_inc,
    output logic [1:0]      pc_sel,
    output logic            ir_ld,
    output logic            im_cs,
    output logic            im_rd,
    output logic            dm_cs,
    output logic            dm_rd,
    output logic            dm_wr,
    output logic            D_En,
    output logic [1:0]      D_sel,
    output logic            T_Sel,
    output logic            HILO_ld,
    output logic [2:0]      Y_Sel,
    output logic [FS_W-1:0] FS,
    output logic            halt,
    output logic            illegal
);

    state_t     r_state, w_next;
    dec_t       w_dec;
    logic [4:0] w_fs;
    logic       w_unused_flags;

    // N/C/V are not used for sequencing
    assign w_unused_flags = N ^ C ^ V;

    mcu_decode u_decode (.i_ir(IR), .o_dec(w_dec));

    assign FS = FS_W'(w_fs);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_RESET;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        pc_ld   = 1'b0;  pc_inc = 1'b0;  pc_sel = PS_INC;
        ir_ld   = 1'b0;  im_cs  = 1'b0;  im_rd  = 1'b0;
        dm_cs   = 1'b0;  dm_rd  = 1'b0;  dm_wr  = 1'b0;
        D_En    = 1'b0;  D_sel  = DS_RD; T_Sel  = 1'b0;
        HILO_ld = 1'b0;  Y_Sel  = YS_HI; w_fs   = FS_PASS_S;
        halt    = 1'b0;  illegal = 1'b0;
        if (reset) begin
            case (r_state)
                S_RESET: begin
                    // initialise $sp from PC_In
                    D_sel = DS_SP; Y_Sel = YS_PC; D_En = 1'b1;
                    w_next = S_FETCH;
                end
                S_FETCH: begin
                    im_cs = 1'b1; im_rd = 1'b1; ir_ld = 1'b1; pc_inc = 1'b1;
                    w_next = S_DECODE;
                end
                S_DECODE: begin
                    T_Sel = w_dec.tsel;
                    case (w_dec.cls)
                        CL_R:    w_next = S_R_EXEC;
                        CL_I:    w_next = S_I_EXEC;
                        CL_MD:   w_next = S_MD_EXEC;
                        CL_MF:   w_next = S_MF_WB;
                        CL_LW,
                        CL_SW:   w_next = S_LS_EXEC;
                        CL_BR:   w_next = S_BR_EXEC;
                        CL_J:    w_next = S_J;
                        CL_JAL:  w_next = S_JAL;
                        CL_JR:   w_next = S_JR;
                        CL_BRK:  w_next = S_HALT;
                        default: w_next = STRICT_ILLEGAL ? S_ILLEGAL : S_FETCH;
                    endcase
                end
                S_R_EXEC:  begin w_fs = w_dec.fs; w_next = S_R_WB; end
                S_R_WB:    begin Y_Sel = YS_ALU; D_sel = w_dec.dest; D_En = 1'b1; w_next = S_FETCH; end
                S_I_EXEC:  begin w_fs = w_dec.fs; T_Sel = 1'b1; w_next = S_I_WB; end
                S_I_WB:    begin Y_Sel = YS_ALU; D_sel = w_dec.dest; D_En = 1'b1; w_next = S_FETCH; end
                S_MD_EXEC: begin w_fs = w_dec.fs; HILO_ld = 1'b1; w_next = S_FETCH; end
                S_MF_WB: begin
                    // funct bit 1 separates mflo (0x12) from mfhi (0x10)
                    Y_Sel = IR[1] ? YS_LO : YS_HI;
                    D_sel = w_dec.dest; D_En = 1'b1; w_next = S_FETCH;
                end
                S_LS_EXEC: begin
                    // address = RS + imm; T_Sel=0 reloads RT with store data
                    w_fs = FS_ADD;
                    w_next = (w_dec.cls == CL_LW) ? S_LW_MEM : S_SW_MEM;
                end
                S_LW_MEM:  begin dm_cs = 1'b1; dm_rd = 1'b1; w_next = S_LW_WB; end
                S_LW_WB:   begin Y_Sel = YS_DIN; D_sel = w_dec.dest; D_En = 1'b1; w_next = S_FETCH; end
                S_SW_MEM:  begin dm_cs = 1'b1; dm_wr = 1'b1; w_next = S_FETCH; end
                S_BR_EXEC: begin
                    w_fs = FS_SUB; pc_sel = PS_BR;
                    // opcode bit 26 distinguishes bne (0x05) from beq (0x04)
                    pc_ld = IR[26] ? ~Z : Z;
                    w_next = S_FETCH;
                end
                S_J:       begin pc_sel = PS_JMP; pc_ld = 1'b1; w_next = S_FETCH; end
                S_JAL: begin
                    pc_sel = PS_JMP; pc_ld = 1'b1;
                    D_sel = DS_R31; Y_Sel = YS_PC; D_En = 1'b1;
                    w_next = S_FETCH;
                end
                S_JR:      begin pc_sel = PS_RS; pc_ld = 1'b1; w_next = S_FETCH; end
                S_HALT:    halt = 1'b1;
                S_ILLEGAL: begin halt = 1'b1; illegal = 1'b1; end
                default:   w_next = S_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_control_unit.sv
// Directed testbench for mips_control_unit.
module tb_mips_control_unit;
    import mips_ctrl_pkg::*;

    logic        clk, reset;
    logic [31:0] IR;
    logic        N, Z, C, V;
    logic        pc_ld, pc_inc, ir_ld, im_cs, im_rd, dm_cs, dm_rd, dm_wr;
    logic        D_En, T_Sel, HILO_ld, halt, illegal;
    logic [1:0]  pc_sel, D_sel;
    logic [2:0]  Y_Sel;
    logic [4:0]  FS;

    int n_tests = 0;
    int n_fail  = 0;

    mips_control_unit #(.STRICT_ILLEGAL(1'b1), .FS_W(5)) dut (
        .clk(clk), .reset(reset), .IR(IR), .N(N), .Z(Z), .C(C), .V(V),
        .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_sel(pc_sel), .ir_ld(ir_ld),
        .im_cs(im_cs), .im_rd(im_rd), .dm_cs(dm_cs), .dm_rd(dm_rd), .dm_wr(dm_wr),
        .D_En(D_En), .D_sel(D_sel), .T_Sel(T_Sel), .HILO_ld(HILO_ld),
        .Y_Sel(Y_Sel), .FS(FS), .halt(halt), .illegal(illegal)
    );

    // every output in one vector; halt is bit 1, illegal bit 0
    logic [24:0] w_outs;
    assign w_outs = {pc_ld, pc_inc, pc_sel, ir_ld, im_cs, im_rd, dm_cs, dm_rd, dm_wr,
                     D_En, D_sel, T_Sel, HILO_ld, Y_Sel, FS, halt, illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; IR = 32'h0; N = 1'b0; Z = 1'b0; C = 1'b0; V = 1'b0;
        #1;
        chk("rst_all_zero", 32'(w_outs), 0);

        // release: one RESET cycle initialising $sp
        @(posedge clk); #1; reset = 1'b1; #1;
        chk("rst_dsel", 32'(D_sel), 3);
        chk("rst_den", 32'(D_En), 1);
        chk("rst_ysel", 32'(Y_Sel), 4);
        tick();
        chk("fetch_irld", 32'(ir_ld), 1);
        chk("fetch_im", 32'({im_cs, im_rd, pc_inc}), 32'h7);
        chk("fetch_den", 32'(D_En), 0);

        // add $3,$1,$2
        IR = 32'h00221820;
        tick(); chk("add_dec_tsel", 32'(T_Sel), 0);
                chk("add_dec_den", 32'(D_En), 0);
        tick(); chk("add_exec_fs", 32'(FS), 32'(FS_ADD));
                chk("add_exec_den", 32'(D_En), 0);
        tick(); chk("add_wb_ysel", 32'(Y_Sel), 2);
                chk("add_wb_dsel", 32'(D_sel), 0);
                chk("add_wb_den", 32'(D_En), 1);
        tick(); chk("add_fetch_den", 32'(D_En), 0);
                chk("add_fetch_irld", 32'(ir_ld), 1);

        // lw $5,8($4)
        IR = 32'h8C850008;
        tick(); chk("lw_dec_tsel", 32'(T_Sel), 1);
        tick(); chk("lw_ls_fs", 32'(FS), 32'(FS_ADD));
                chk("lw_ls_tsel", 32'(T_Sel), 0);
        tick(); chk("lw_mem", 32'({dm_cs, dm_rd, dm_wr, D_En}), 32'hC);
        tick(); chk("lw_wb_ysel", 32'(Y_Sel), 3);
                chk("lw_wb_dsel", 32'(D_sel), 1);
                chk("lw_wb_den", 32'(D_En), 1);
        tick(); chk("lw_fetch", 32'({ir_ld, D_En}), 32'h2);

        // sw $5,8($4)
        IR = 32'hAC850008;
        tick(); chk("sw_dec_tsel", 32'(T_Sel), 1);
        tick(); chk("sw_ls_tsel", 32'(T_Sel), 0);
                chk("sw_ls_fs", 32'(FS), 32'(FS_ADD));
        tick(); chk("sw_mem", 32'({dm_cs, dm_rd, dm_wr, D_En}), 32'hA);
        tick(); chk("sw_fetch", 32'({ir_ld, dm_wr}), 32'h2);

        // beq $1,$2,+4 : taken on Z=1, not taken on Z=0 (same cycle)
        IR = 32'h10220004; Z = 1'b1;
        tick();
        tick(); chk("beq_fs", 32'(FS), 32'(FS_SUB));
                chk("beq_z1_pcld", 32'(pc_ld), 1);
                chk("beq_z1_pcsel", 32'(pc_sel), 1);
        Z = 1'b0; #1;
                chk("beq_z0_pcld", 32'(pc_ld), 0);
        tick(); chk("beq_fetch_pcld", 32'(pc_ld), 0);

        // bne $1,$2,+4 : inverse
        IR = 32'h14220004; Z = 1'b1;
        tick();
        tick(); chk("bne_z1_pcld", 32'(pc_ld), 0);
        Z = 1'b0; #1;
                chk("bne_z0_pcld", 32'(pc_ld), 1);
                chk("bne_z0_pcsel", 32'(pc_sel), 1);
        tick(); chk("bne_fetch", 32'({ir_ld, pc_ld}), 32'h2);

        // jal 0x0100
        IR = 32'h0C000040;
        tick();
        tick(); chk("jal_pc", 32'({pc_sel, pc_ld}), 32'h7);
                chk("jal_link", 32'({D_sel, Y_Sel, D_En}), 32'h29);
        tick(); chk("jal_fetch", 32'({pc_ld, D_En, ir_ld}), 32'h1);

        // mult then mflo $3
        IR = 32'h00220018;
        tick();
        tick(); chk("mult_hilo", 32'(HILO_ld), 1);
                chk("mult_fs", 32'(FS), 32'(FS_MUL));
        tick(); chk("mult_fetch_hilo", 32'({HILO_ld, ir_ld}), 32'h1);
        IR = 32'h00001812;
        tick();
        tick(); chk("mflo_wb", 32'({Y_Sel, D_sel, D_En}), 32'h9);
        tick(); chk("mflo_fetch", 32'({D_En, ir_ld}), 32'h1);

        // break -> HALT, sticky with all strobes low
        IR = 32'h0000000D;
        tick();
        tick(); chk("brk_halt", 32'(w_outs), 32'h2);
        tick(); tick();
                chk("brk_halt_held", 32'(w_outs), 32'h2);

        // reset asserted in the middle of a lw (LW_MEM)
        reset = 1'b0; #1;
        chk("halt_rst_zero", 32'(w_outs), 0);
        @(posedge clk); #1; reset = 1'b1; #1;
        tick();
        IR = 32'h8C850008;
        tick(); tick(); tick();
        chk("lw2_mem_rd", 32'(dm_rd), 1);
        #2; reset = 1'b0; #1;
        chk("midlw_rst_zero", 32'(w_outs), 0);
        @(posedge clk); #1; reset = 1'b1; #1;
        chk("rel_reset_state", 32'({D_sel, D_En, ir_ld}), 32'hE);
        tick();
        chk("rel_fetch", 32'({ir_ld, D_En, dm_rd}), 32'h4);

        // undefined opcode -> ILLEGAL, held until reset
        IR = 32'hFC000000;
        tick();
        tick(); chk("ill_state", 32'(w_outs), 32'h3);
        tick(); tick(); tick();
                chk("ill_held", 32'(w_outs), 32'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
